// File: rtl/syn_down_c.sv
// Synchronous down counter with load, halt-at-zero or wrap mode,
// registered borrow pulse and sticky done flag.
module syn_down_c #(
   parameter int reg_size = 4
) (
   input  logic                clk,
   input  logic                clr,
   input  logic                en,
   input  logic                ld,
   input  logic [reg_size-1:0] d,
   input  logic                stop,
   output logic [reg_size-1:0] q,
   output logic                tc,
   output logic                bo,
   output logic                done
);

   logic                zero;
   logic                one;
   logic                cnt;
   logic [reg_size-1:0] tog;

   assign zero = (q == '0);
   assign one  = (q == reg_size'(1));
   assign tc   = zero;

   // Halted at zero in stop mode: the chain stays frozen.
   assign cnt  = en & ~(zero & stop);

   assign tog[0] = cnt;

   for (genvar j = 1; j < reg_size; j++) begin : g_tog
      assign tog[j] = cnt & (q[j-1:0] == '0);
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         q    <= '0;
         bo   <= 1'b0;
         done <= 1'b0;
      end else if (ld) begin
         q    <= d;
         bo   <= 1'b0;
         done <= 1'b0;
      end else begin
         q  <= q ^ tog;
         bo <= cnt & zero;
         if (cnt & stop & one)
            done <= 1'b1;
      end
   end

endmodule

// File: tb/tb_syn_down_c.sv
// Scoreboard bench for syn_down_c: driver pushes model results,
// monitor pops and compares one edge later.
module tb_syn_down_c;

   localparam int W    = 4;
   localparam int MAXV = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         clr = 1'b1;
   logic         en = 1'b0;
   logic         ld = 1'b0;
   logic [W-1:0] d = '0;
   logic         stop = 1'b0;
   logic [W-1:0] q;
   logic         tc;
   logic         bo;
   logic         done;

   typedef struct {
      int q;
      bit bo;
      bit done;
   } exp_t;

   exp_t sb[$];

   int vectors = 0;
   int errors  = 0;

   int mq    = 0;
   bit mbo   = 0;
   bit mdone = 0;

   syn_down_c #(.reg_size(W)) dut (
      .clk  (clk),
      .clr  (clr),
      .en   (en),
      .ld   (ld),
      .d    (d),
      .stop (stop),
      .q    (q),
      .tc   (tc),
      .bo   (bo),
      .done (done)
   );

   always #5 clk = ~clk;

   task automatic apply(input bit c, input bit l, input bit e,
                        input bit s, input int dv);
      @(negedge clk);
      clr  = c;
      ld   = l;
      en   = e;
      stop = s;
      d    = W'(dv);
      if (c) begin
         mq = 0; mbo = 0; mdone = 0;
      end else if (l) begin
         mq = dv % (MAXV + 1); mbo = 0; mdone = 0;
      end else if (e) begin
         if (mq == 0) begin
            if (s) mbo = 0;
            else begin mq = MAXV; mbo = 1; end
         end else begin
            mq  = mq - 1;
            mbo = 0;
            if (mq == 0 && s) mdone = 1;
         end
      end else begin
         mbo = 0;
      end
      sb.push_back('{mq, mbo, mdone});
   endtask

   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         vectors++;
         if (q !== W'(e.q) || bo !== e.bo || done !== e.done ||
             tc !== (e.q == 0)) begin
            errors++;
            $display("FAIL vec%0d: got q=%0d tc=%b bo=%b done=%b, want q=%0d tc=%b bo=%b done=%b",
                     vectors, q, tc, bo, done, e.q, (e.q == 0), e.bo, e.done);
         end
      end
   end

   initial begin
      // reset, then clr overriding ld and en from q=9
      apply(1, 0, 0, 0, 0);
      apply(0, 1, 0, 0, 9);
      apply(1, 1, 1, 0, 5);
      // load 3, halt at zero
      apply(0, 1, 0, 1, 3);
      repeat (5) apply(0, 0, 1, 1, 0);
      // load 1, wrap mode
      apply(0, 1, 0, 0, 1);
      repeat (3) apply(0, 0, 1, 0, 0);
      // load beats en
      apply(0, 1, 0, 0, 5);
      apply(0, 1, 1, 1, 12);
      // en toggling
      apply(0, 1, 0, 0, 8);
      apply(0, 0, 1, 0, 0);
      apply(0, 0, 0, 0, 0);
      apply(0, 0, 1, 0, 0);
      // done sticky across modes, then ld of zero keeps done low
      apply(0, 1, 0, 1, 2);
      repeat (3) apply(0, 0, 1, 1, 0);
      apply(0, 0, 1, 0, 0);
      apply(0, 0, 0, 0, 0);
      apply(0, 1, 0, 1, 0);
      repeat (2) apply(0, 0, 1, 1, 0);
      // full-period wrap from reset
      apply(1, 0, 0, 0, 0);
      repeat (32) apply(0, 0, 1, 0, 0);
      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         int r;
         r = $urandom_range(0, 99);
         apply(r < 3, r >= 3 && r < 12, $urandom_range(0, 3) != 0,
               $urandom_range(0, 1) == 1, $urandom_range(0, MAXV));
      end
      repeat (3) @(negedge clk);
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
